// File: rtl/serial_decoder_controller.sv
// Start-bit-aligned serial frame decoder: deserialises LSB-first bytes, checks
// even parity and the stop bit, and queues good bytes in a 2-entry output buffer.
module serial_decoder_controller #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 1,
   parameter int FIFO_DEPTH = 2
) (
   input  logic       clock,
   input  logic       _reset,
   input  logic       serialIn,
   input  logic       enable,
   output logic [7:0] byteOut,
   output logic       byteValid,
   input  logic       byteReady,
   output logic       parityError,
   output logic       framingError,
   output logic       overrun,
   output logic       busy,
   output logic [7:0] frameCount,
   output logic [1:0] debug_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   generate
      if (FIFO_DEPTH != 2) begin : g_depth_check
         $error("serial_decoder_controller: output buffer is fixed at 2 entries");
      end
      if (DATA_BITS < 1 || DATA_BITS > 8) begin : g_width_check
         $error("serial_decoder_controller: DATA_BITS must be 1..8");
      end
   endgenerate

   state_t     state, state_nxt;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       par_bad_q, par_bad_d;
   logic       stop_sample;

   logic [7:0] mem [2];
   logic       wr_ptr, rd_ptr;
   logic [1:0] count;
   logic       full, push, pop, good_frame;
   logic       drop_framing, drop_parity, drop_overrun;

   // Frame sequencing; a low enable in any active state abandons the frame.
   always_comb begin
      state_nxt   = state;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      par_bad_d   = par_bad_q;
      stop_sample = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable && !serialIn) begin
               state_nxt = S_DATA;
               bit_cnt_d = 3'd0;
               shift_d   = 8'h00;
               par_bad_d = 1'b0;
            end
         end
         S_DATA: begin
            shift_d                = shift_q >> 1;
            shift_d[DATA_BITS - 1] = serialIn;
            bit_cnt_d              = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
               state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            par_bad_d = (^shift_q) ^ serialIn;
            state_nxt = S_STOP;
         end
         S_STOP: begin
            stop_sample = 1'b1;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (!enable && state != S_IDLE) begin
         state_nxt   = S_IDLE;
         stop_sample = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         state     <= S_IDLE;
         shift_q   <= 8'h00;
         bit_cnt_q <= 3'd0;
         par_bad_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_bad_q <= par_bad_d;
      end
   end

   // Handshake: the head byte transfers on any rising edge where byteValid and
   // byteReady are both 1; byteOut holds steady while byteValid=1 and byteReady=0.
   assign full         = (count == 2'd2);
   assign pop          = byteValid & byteReady;
   assign drop_framing = stop_sample & ~serialIn;
   assign drop_parity  = stop_sample & serialIn & par_bad_q;
   assign good_frame   = stop_sample & serialIn & ~par_bad_q;
   assign push         = good_frame & (~full | pop);
   assign drop_overrun = good_frame & full & ~pop;

   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         mem[0]       <= 8'h00;
         mem[1]       <= 8'h00;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= 2'd0;
         frameCount   <= 8'h00;
         parityError  <= 1'b0;
         framingError <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         // At full, the write slot equals the head slot being popped this edge.
         if (push) begin
            mem[wr_ptr] <= shift_q;
            wr_ptr      <= ~wr_ptr;
            frameCount  <= frameCount + 8'd1;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         parityError  <= drop_parity;
         framingError <= drop_framing;
         overrun      <= drop_overrun;
      end
   end

   assign byteValid   = (count != 2'd0);
   assign byteOut     = byteValid ? mem[rd_ptr] : 8'h00;
   assign busy        = (state != S_IDLE);
   assign debug_state = state;

endmodule

// File: tb/tb_serial_decoder_controller.sv
// Directed bench for serial_decoder_controller: 8 data bits, even parity,
// inputs driven and outputs sampled 1 ns after each rising edge.
module tb_serial_decoder_controller;

   logic       clock;
   logic       _reset;
   logic       serialIn;
   logic       enable;
   logic [7:0] byteOut;
   logic       byteValid;
   logic       byteReady;
   logic       parityError;
   logic       framingError;
   logic       overrun;
   logic       busy;
   logic [7:0] frameCount;
   logic [1:0] debug_state;

   int errors = 0;
   int checks = 0;

   serial_decoder_controller #(
      .DATA_BITS (8),
      .PARITY_EN (1),
      .FIFO_DEPTH(2)
   ) dut (
      .clock       (clock),
      ._reset      (_reset),
      .serialIn    (serialIn),
      .enable      (enable),
      .byteOut     (byteOut),
      .byteValid   (byteValid),
      .byteReady   (byteReady),
      .parityError (parityError),
      .framingError(framingError),
      .overrun     (overrun),
      .busy        (busy),
      .frameCount  (frameCount),
      .debug_state (debug_state)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      _reset = 1'b0;
      serialIn = 1'b1;
      tick();
      tick();
      _reset = 1'b1;
      tick();
   endtask

   // driver tasks
   task automatic send_bit(input logic b);
      serialIn = b;
      tick();
   endtask

   // Start, 8 data bits LSB-first, parity, stop; optionally raises byteReady
   // only for the cycle whose edge samples the stop bit.
   task automatic send_frame(input logic [7:0] data, input logic par,
                             input logic stop, input logic ready_at_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      send_bit(par);
      if (ready_at_stop) byteReady = 1'b1;
      send_bit(stop);
      if (ready_at_stop) byteReady = 1'b0;
      serialIn = 1'b1;
   endtask

   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

   task automatic test_reset();
      enable = 1'b1;
      byteReady = 1'b0;
      _reset = 1'b0;
      serialIn = 1'b1;
      tick();
      checks++; if (byteOut !== 8'h00) begin errors++; $display("FAIL reset_byteOut: got %h want 00", byteOut); end
      checks++; if (byteValid !== 1'b0) begin errors++; $display("FAIL reset_byteValid: got %b want 0", byteValid); end
      checks++; if ({parityError, framingError, overrun} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {parityError, framingError, overrun}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (frameCount !== 8'h00) begin errors++; $display("FAIL reset_frameCount: got %h want 00", frameCount); end
      checks++; if (debug_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", debug_state); end
      _reset = 1'b1;
      tick();
   endtask

   task automatic test_good_frame();
      do_reset();
      byteReady = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      checks++; if (byteValid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b want 1", byteValid); end
      checks++; if (byteOut !== 8'hA5) begin errors++; $display("FAIL good_byteOut: got %h want a5", byteOut); end
      checks++; if (frameCount !== 8'd1) begin errors++; $display("FAIL good_frameCount: got %0d want 1", frameCount); end
      checks++; if ({parityError, framingError, overrun} !== 3'b000) begin errors++; $display("FAIL good_pulses: got %b want 000", {parityError, framingError, overrun}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_after_stop: got %b want 0", busy); end
      tick();
      checks++; if (byteValid !== 1'b0) begin errors++; $display("FAIL good_popped_valid: got %b want 0", byteValid); end
      checks++; if (byteOut !== 8'h00) begin errors++; $display("FAIL good_empty_byteOut: got %h want 00", byteOut); end
   endtask

   task automatic test_errors();
      do_reset();
      byteReady = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
      checks++; if (parityError !== 1'b1) begin errors++; $display("FAIL par_pulse: got %b want 1", parityError); end
      checks++; if (framingError !== 1'b0) begin errors++; $display("FAIL par_no_framing: got %b want 0", framingError); end
      checks++; if (byteValid !== 1'b0) begin errors++; $display("FAIL par_valid: got %b want 0", byteValid); end
      checks++; if (frameCount !== 8'd0) begin errors++; $display("FAIL par_frameCount: got %0d want 0", frameCount); end
      tick();
      checks++; if (parityError !== 1'b0) begin errors++; $display("FAIL par_pulse_width: got %b want 0", parityError); end
      send_frame(8'h3C, even_par(8'h3C), 1'b0, 1'b0);
      checks++; if (framingError !== 1'b1) begin errors++; $display("FAIL frm_pulse: got %b want 1", framingError); end
      checks++; if (parityError !== 1'b0) begin errors++; $display("FAIL frm_no_parity: got %b want 0", parityError); end
      checks++; if (byteValid !== 1'b0) begin errors++; $display("FAIL frm_valid: got %b want 0", byteValid); end
      tick();
      checks++; if (framingError !== 1'b0) begin errors++; $display("FAIL frm_pulse_width: got %b want 0", framingError); end
      // bad parity and bad stop together: framing wins
      send_frame(8'h3C, ~even_par(8'h3C), 1'b0, 1'b0);
      checks++; if ({framingError, parityError} !== 2'b10) begin errors++; $display("FAIL frm_precedence: got %b want 10", {framingError, parityError}); end
      checks++; if (frameCount !== 8'd0) begin errors++; $display("FAIL err_frameCount: got %0d want 0", frameCount); end
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      byteReady = 1'b0;
      send_frame(8'h11, even_par(8'h11), 1'b1, 1'b0);
      checks++; if (byteOut !== 8'h11 || byteValid !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b want 11/1", byteOut, byteValid); end
      send_frame(8'h22, even_par(8'h22), 1'b1, 1'b0);
      checks++; if (frameCount !== 8'd2) begin errors++; $display("FAIL b2b_frameCount2: got %0d want 2", frameCount); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun: got %b want 0", overrun); end
      send_frame(8'h33, even_par(8'h33), 1'b1, 1'b0);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
      checks++; if (frameCount !== 8'd2) begin errors++; $display("FAIL b2b_frameCount_hold: got %0d want 2", frameCount); end
      checks++; if (byteOut !== 8'h11) begin errors++; $display("FAIL b2b_head_hold: got %h want 11", byteOut); end
      byteReady = 1'b1;
      tick();
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_width: got %b want 0", overrun); end
      checks++; if (byteOut !== 8'h22) begin errors++; $display("FAIL b2b_second: got %h want 22", byteOut); end
      tick();
      checks++; if (byteValid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", byteValid); end
      byteReady = 1'b0;
   endtask

   task automatic test_pop_on_stop();
      do_reset();
      byteReady = 1'b0;
      send_frame(8'h11, even_par(8'h11), 1'b1, 1'b0);
      send_frame(8'h22, even_par(8'h22), 1'b1, 1'b0);
      send_frame(8'h44, even_par(8'h44), 1'b1, 1'b1);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pos_no_overrun: got %b want 0", overrun); end
      checks++; if (frameCount !== 8'd3) begin errors++; $display("FAIL pos_frameCount: got %0d want 3", frameCount); end
      checks++; if (byteOut !== 8'h22) begin errors++; $display("FAIL pos_head: got %h want 22", byteOut); end
      byteReady = 1'b1;
      tick();
      checks++; if (byteOut !== 8'h44) begin errors++; $display("FAIL pos_tail: got %h want 44", byteOut); end
      tick();
      checks++; if (byteValid !== 1'b0) begin errors++; $display("FAIL pos_drained: got %b want 0", byteValid); end
      byteReady = 1'b0;
   endtask

   task automatic test_abort();
      do_reset();
      byteReady = 1'b0;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
      enable = 1'b0;
      serialIn = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", busy); end
      checks++; if ({parityError, framingError, overrun, byteValid} !== 4'b0000) begin errors++; $display("FAIL abort_quiet: got %b want 0000", {parityError, framingError, overrun, byteValid}); end
      // enable low also blocks start detection
      serialIn = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_disabled_start: got %b want 0", busy); end
      serialIn = 1'b1;
      enable = 1'b1;
      tick();
      send_frame(8'h5A, even_par(8'h5A), 1'b1, 1'b0);
      checks++; if (byteOut !== 8'h5A || byteValid !== 1'b1) begin errors++; $display("FAIL abort_resume: got %h/%b want 5a/1", byteOut, byteValid); end
      checks++; if (frameCount !== 8'd1) begin errors++; $display("FAIL abort_frameCount: got %0d want 1", frameCount); end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      byteReady = 1'b0;
      send_frame(8'h11, even_par(8'h11), 1'b1, 1'b0);
      send_frame(8'h22, even_par(8'h22), 1'b1, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      #2;
      _reset = 1'b0;
      #1;
      checks++; if (byteValid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", byteValid); end
      checks++; if (byteOut !== 8'h00) begin errors++; $display("FAIL async_byteOut: got %h want 00", byteOut); end
      checks++; if (frameCount !== 8'h00) begin errors++; $display("FAIL async_frameCount: got %0d want 0", frameCount); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy); end
      serialIn = 1'b1;
      @(negedge clock);
      _reset = 1'b1;
      tick();
      send_frame(8'h81, even_par(8'h81), 1'b1, 1'b0);
      checks++; if (byteOut !== 8'h81 || byteValid !== 1'b1) begin errors++; $display("FAIL async_next_frame: got %h/%b want 81/1", byteOut, byteValid); end
      checks++; if (frameCount !== 8'd1) begin errors++; $display("FAIL async_next_count: got %0d want 1", frameCount); end
   endtask

   initial begin
      _reset = 1'b0;
      serialIn = 1'b1;
      enable = 1'b1;
      byteReady = 1'b0;
      test_reset();
      test_good_frame();
      test_errors();
      test_back_to_back();
      test_pop_on_stop();
      test_abort();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
